pipe_stage_reg: RTL

Parametrised elastic inter-stage register that replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries an opaque payload of configurable width under a valid/ready handshake, inserts a bubble payload when empty, and supports flush. In skid mode it registers the backpressure path to break the combinational ready chain between stages. A saturating counter reports stall cycles for performance analysis.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_sat_cnt.sv | 31 +++
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the elastic inter-stage register.
package pipe_pkg;

    localparam int MODE_PASS = 0;
    localparam int MODE_SKID = 1;

    // Payload shown and stored when no valid entry exists (a nop).
    localparam logic [31:0] BUBBLE_DEFAULT = 32'h0000_0000;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with enable; holds at all-ones, cleared only by reset.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register: single-entry pass-through or two-entry
// skid buffer, with flush, bubble payload and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter int               MODE   = MODE_PASS,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_DEFAULT),
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output occ_t             occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Handshake: a beat moves when valid && ready on a rising edge; valid never
    // waits on ready, and a presented beat holds its payload until it moves.
    logic accept;
    logic emit;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    if (MODE == MODE_PASS) begin : g_pass
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] data_q, data_d;

        // Downstream ready feeds straight through to upstream ready.
        assign in_ready = reset && !flush && (!valid_q || out_ready);

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (flush) begin
                valid_d = 1'b0;
                data_d  = BUBBLE;
            end else if (accept) begin
                valid_d = 1'b1;
                data_d  = in_data;
            end else if (emit) begin
                valid_d = 1'b0;
                data_d  = BUBBLE;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_q <= 1'b0;
                data_q  <= BUBBLE;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign occupancy = {1'b0, valid_q};
    end else if (MODE == MODE_SKID) begin : g_skid
        logic             main_valid_q, main_valid_d;
        logic [WIDTH-1:0] main_data_q, main_data_d;
        logic             skid_valid_q, skid_valid_d;
        logic [WIDTH-1:0] skid_data_q, skid_data_d;
        occ_t             occ_q, occ_d;

        // Upstream ready comes from a register, cutting the ready chain.
        assign in_ready = reset && !flush && !skid_valid_q;

        always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (flush) begin
                main_valid_d = 1'b0;
                main_data_d  = BUBBLE;
                skid_valid_d = 1'b0;
                skid_data_d  = BUBBLE;
            end else if (emit) begin
                if (skid_valid_q) begin
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                    skid_data_d  = BUBBLE;
                end else if (accept) begin
                    main_data_d = in_data;
                end else begin
                    main_valid_d = 1'b0;
                    main_data_d  = BUBBLE;
                end
            end else if (accept) begin
                if (!main_valid_q) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                end
            end
            occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                main_valid_q <= 1'b0;
                main_data_q  <= BUBBLE;
                skid_valid_q <= 1'b0;
                skid_data_q  <= BUBBLE;
                occ_q        <= '0;
            end else begin
                main_valid_q <= main_valid_d;
                main_data_q  <= main_data_d;
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
                occ_q        <= occ_d;
            end
        end

        assign out_valid = main_valid_q;
        assign out_data  = main_data_q;
        assign occupancy = occ_q;
    end else begin : g_bad_mode
        $error("pipe_stage_reg: MODE must be MODE_PASS or MODE_SKID");
    end

    pipe_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (out_valid && !out_ready),
        .cnt  (stall_cnt)
    );

endmodule
